// File: rtl/s_mem_reader.sv
// s_mem_reader: streams the S-array RAM out over valid/ready with credit-based reads; SMEM_CHECK_EN adds identity-fill checking
module s_mem_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              mismatch,
  output logic [ADDR_W-1:0] err_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_W:0] cnt;
  logic [RD_LATENCY-1:0] pv;
  logic [ADDR_W-1:0] pa [RD_LATENCY];
  logic [DATA_W-1:0] fd [4];
  logic [ADDR_W-1:0] fa [4];
  logic [1:0] wp, rp;
  logic [2:0] occ, infl;
  logic push, pop;
  assign infl = 3'($countones(pv));
  assign rden = state == ISSUE && (occ + infl) < 3'd4;
  assign wren = 1'b0;
  assign address = cnt[ADDR_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign push = pv[RD_LATENCY-1];
  assign out_valid = occ != 3'd0;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? fd[rp] : '0;
  assign out_addr = out_valid ? fa[rp] : '0;
  assign out_last = out_valid && &out_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pv <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      pv <= (pv << 1) | RD_LATENCY'(rden);
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      occ <= occ + 3'(push) - 3'(pop);
      case (state)
        IDLE: if (start) state <= ISSUE;
        ISSUE: if (rden) begin
          cnt <= cnt + 1'b1;
          if (cnt == {1'b0, {ADDR_W{1'b1}}}) state <= DRAIN;
        end
        DRAIN: if (occ == 3'd0 && pv == '0) state <= DONE;
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
  // tag pipe and FIFO storage need no reset: pv and occ qualify every entry
  always_ff @(posedge clk) begin
    pa[0] <= address;
    for (int i = 1; i < RD_LATENCY; i++) pa[i] <= pa[i-1];
    if (push) begin
      fd[wp] <= q;
      fa[wp] <= pa[RD_LATENCY-1];
    end
  end
`ifdef SMEM_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      mismatch <= 1'b0;
      err_addr <= '0;
    end else if (pop && !mismatch && out_data != out_addr[DATA_W-1:0]) begin
      mismatch <= 1'b1;
      err_addr <= out_addr;
    end
  end
`else
  assign mismatch = 1'b0;
  assign err_addr = '0;
`endif
endmodule

// File: tb/tb_s_mem_reader.sv
// tb_s_mem_reader: drives RD_LATENCY=1 and =2 readers side by side against a RAM model and an in-order stream model
module tb_s_mem_reader;
`ifdef SMEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    int mode;
    bit corrupt;
    bit exp_mis;
    int exp_err;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ready = 1'b1;
  logic [7:0] S [256];
  logic busy_w[2], done_w[2], rden_w[2], wren_w[2], valid_w[2], last_w[2], mis_w[2];
  logic [7:0] addr_w[2], q_w[2], od_w[2], oa_w[2], err_w[2];
  logic [7:0] r1;
  logic hold[2];
  logic [7:0] hd[2], ha[2];
  int checks = 0, errors = 0, cyc = 0, s0 = 0, mode = 0;
  int nbytes[2], nlast[2], ndone[2], issued[2], popped[2], fv_lat[2], dn_lat[2];
  vec_t v[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  s_mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .address(addr_w[0]), .rden(rden_w[0]), .wren(wren_w[0]), .q(q_w[0]),
    .out_data(od_w[0]), .out_addr(oa_w[0]), .out_valid(valid_w[0]), .out_ready(ready),
    .out_last(last_w[0]), .mismatch(mis_w[0]), .err_addr(err_w[0]));
  s_mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .address(addr_w[1]), .rden(rden_w[1]), .wren(wren_w[1]), .q(q_w[1]),
    .out_data(od_w[1]), .out_addr(oa_w[1]), .out_valid(valid_w[1]), .out_ready(ready),
    .out_last(last_w[1]), .mismatch(mis_w[1]), .err_addr(err_w[1]));

  always @(posedge clk) begin
    q_w[0] <= S[addr_w[0]];
    r1 <= S[addr_w[1]];
    q_w[1] <= r1;
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[lat%0d]: got %0d expected %0d", name, k + 1, act, exp);
    end
  endtask

  task automatic clr(input int k);
    nbytes[k] = 0; nlast[k] = 0; ndone[k] = 0; issued[k] = 0; popped[k] = 0;
    fv_lat[k] = -1; dn_lat[k] = -1;
  endtask

  initial begin
    int st;
    st = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: ready = 1'b1;
        1: ready = ~ready;
        2: if (st > 0) begin ready = 1'b0; st--; end
           else if ($urandom_range(0, 24) == 0) begin ready = 1'b0; st = 9; end
           else ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin clr(k); hold[k] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          clr(k);
          hold[k] = 1'b0;
        end else begin
          if (hold[k]) begin
            chk("stall_valid", k, valid_w[k], 1);
            chk("stall_data", k, od_w[k], hd[k]);
            chk("stall_addr", k, oa_w[k], ha[k]);
          end
          hold[k] = valid_w[k] && !ready;
          hd[k] = od_w[k];
          ha[k] = oa_w[k];
          if (valid_w[k] && fv_lat[k] < 0) fv_lat[k] = cyc - s0;
          if (rden_w[k]) begin
            chk("rden_credit", k, int'(issued[k] - popped[k] < 4), 1);
            chk("rd_addr", k, addr_w[k], issued[k] % 256);
            issued[k]++;
          end
          if (valid_w[k] && ready) begin
            chk("out_data", k, od_w[k], S[nbytes[k] % 256]);
            chk("out_addr", k, oa_w[k], nbytes[k] % 256);
            chk("out_last", k, last_w[k], int'(nbytes[k] % 256 == 255));
            nlast[k] += int'(last_w[k]);
            nbytes[k]++;
            popped[k]++;
          end
          if (done_w[k]) begin
            if (dn_lat[k] < 0) dn_lat[k] = cyc - s0;
            ndone[k]++;
            chk("done_after_last", k, nbytes[k], 256);
          end
        end
      end
    end
  end

  task automatic pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s0 = cyc;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(ndone[0] > 0 && ndone[1] > 0) && t < 6000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_timeout", 0, int'(t < 6000), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while (nbytes[0] < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("byte_timeout", 0, int'(t < 3000), 1);
  endtask

  task automatic zero_chk();
    for (int k = 0; k < 2; k++) begin
      chk("rst_flags", k, {busy_w[k], done_w[k], rden_w[k], valid_w[k], last_w[k], mis_w[k]}, 0);
      chk("rst_address", k, addr_w[k], 0);
      chk("rst_out_data", k, od_w[k], 0);
      chk("rst_out_addr", k, oa_w[k], 0);
      chk("rst_err_addr", k, err_w[k], 0);
    end
  endtask

  task automatic sweep(input vec_t x);
    mode = x.mode;
    if (x.corrupt) begin S[8'h37] = 8'hAA; S[8'h80] = 8'h00; end
    clr(0); clr(1);
    pulse();
    wait_done();
    for (int k = 0; k < 2; k++) begin
      chk("bytes", k, nbytes[k], 256);
      chk("lasts", k, nlast[k], 1);
      chk("dones", k, ndone[k], 1);
      chk("reads", k, issued[k], 256);
      chk("busy_after", k, busy_w[k], 0);
      chk("wren", k, wren_w[k], 0);
      chk("mismatch", k, mis_w[k], x.exp_mis);
      if (x.exp_mis) chk("err_addr", k, err_w[k], x.exp_err);
      if (x.mode == 0) begin
        chk("first_valid_lat", k, fv_lat[k], k + 2);
        chk("sweep_cycles", k, dn_lat[k], 256 + k + 1 + 2);
      end
    end
    for (int i = 0; i < 256; i++) S[i] = 8'(i);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) S[i] = 8'(i);
    v[0] = '{0, 1'b0, 1'b0, 0};
    v[1] = '{1, 1'b0, 1'b0, 0};
    v[2] = '{2, 1'b0, 1'b0, 0};
    v[3] = '{3, 1'b1, CHK, CHK ? 'h37 : 0};
    v[4] = '{0, 1'b0, 1'b0, 0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    zero_chk();
    for (int i = 0; i < 5; i++) sweep(v[i]);
    // start during a sweep must be ignored
    mode = 0;
    clr(0); clr(1);
    pulse();
    wait_bytes(100);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    for (int k = 0; k < 2; k++) begin
      chk("restart_bytes", k, nbytes[k], 256);
      chk("restart_dones", k, ndone[k], 1);
      chk("restart_reads", k, issued[k], 256);
    end
    sweep(v[0]);
    // reset mid-sweep flushes everything in flight
    mode = 3;
    clr(0); clr(1);
    pulse();
    wait_bytes(50);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    zero_chk();
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("stale_bytes", k, nbytes[k], 0);
      chk("stale_reads", k, issued[k], 0);
    end
    sweep(v[0]);
    sweep(v[2]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
